// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mdu
//  Purpose  : RV32I execute ALU with RV32M multiply/divide behind a
//             valid/ready handshake on both sides. Base operations and
//             divide corner cases complete in one cycle. Multiply and divide
//             are iterative radix-2 units working on operand magnitudes,
//             followed by a sign-fix cycle.
//  Options  : define ALU_FAST_MUL_EN to replace the iterative multiplier
//             with a single combinational XLEN x XLEN multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mdu #(
  parameter  int XLEN  = 32,
  parameter  int M_EXT = 1,
  localparam int SW    = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [SW-1:0]   shamt,
  input  logic            isALUreg,
  input  logic            isALUimm,
  input  logic            isAUIPC,
  input  logic            isLUI,
  input  logic            isJAL,
  input  logic            isJALR,
  input  logic            isLoad,
  input  logic            isStore,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Q,
  output logic            EQ,
  output logic            LT,
  output logic            LTU
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state;
  logic [SW-1:0]       count;
  logic [2*XLEN-1:0]   acc;      // mul: {partial high, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]     opb;      // mul: multiplicand magnitude; div: divisor magnitude
  logic [2:0]          op_f3;
  logic                op_div;
  logic                neg_q;    // product / quotient must be negated
  logic                neg_r;    // remainder must be negated

  // ---------------------------------------------------------------------------
  // Decode and operand preparation
  // ---------------------------------------------------------------------------
  logic            is_m, is_mul, is_div;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, is_special;
  logic [XLEN-1:0] special_res;

  assign is_m   = (M_EXT != 0) && isALUreg && (func7 == 7'b0000001);
  assign is_mul = is_m && !func3[2];
  assign is_div = is_m &&  func3[2];

  // Divides are signed when func3[0]==0; MULHU is the only fully unsigned
  // multiply and MULHSU treats only B as unsigned.
  assign a_signed = func3[2] ? !func3[0] : (func3 != 3'b011);
  assign b_signed = func3[2] ? !func3[0] : !func3[1];
  assign a_neg    = a_signed & A[XLEN-1];
  assign b_neg    = b_signed & B[XLEN-1];
  assign a_mag    = a_neg ? -A : A;
  assign b_mag    = b_neg ? -B : B;

  assign div_zero   = (B == '0);
  assign div_ovf    = !func3[0] && (A == MIN_NEG) && (B == '1);
  assign is_special = is_div && (div_zero || div_ovf);
  // func3[1] separates REM/REMU from DIV/DIVU.
  assign special_res = div_zero ? (func3[1] ? A : '1)
                                : (func3[1] ? '0 : A);

  // ---------------------------------------------------------------------------
  // Base RV32I result
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] base_res;
  logic [XLEN-1:0] sra_res;
  logic            lt_s, lt_u;

  assign sra_res = $signed(A) >>> shamt;
  assign lt_s    = $signed(A) < $signed(B);
  assign lt_u    = A < B;

  // Select the base-op result from the instruction class and func3
  always_comb begin
    base_res = '0;
    if (isALUreg || isALUimm) begin
      case (func3)
        3'b000:  base_res = (isALUreg && func7[5]) ? (A - B) : (A + B);
        3'b001:  base_res = A << shamt;
        3'b010:  base_res = {{(XLEN-1){1'b0}}, lt_s};
        3'b011:  base_res = {{(XLEN-1){1'b0}}, lt_u};
        3'b100:  base_res = A ^ B;
        3'b101:  base_res = func7[5] ? sra_res : (A >> shamt);
        3'b110:  base_res = A | B;
        default: base_res = A & B;
      endcase
    end else if (isAUIPC) begin
      base_res = A + B;
    end else if (isLUI) begin
      base_res = B;
    end else if (isJAL || isJALR) begin
      base_res = A + XLEN'(4);
    end else if (isLoad || isStore) begin
      base_res = A + B;
    end
  end

  // ---------------------------------------------------------------------------
  // Iteration datapaths and final sign correction
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  // Shift-add: add the multiplicand into the high half when the current
  // multiplier bit is set; the carry becomes the new top bit after the shift.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);

  // Restoring step: the partial remainder shifted left by one is XLEN+1 bits.
  // When it is >= divisor the true difference fits in XLEN bits.
  assign div_ge  = acc[2*XLEN-1:XLEN-1] >= {1'b0, opb};
  assign div_sub = acc[2*XLEN-2:XLEN-1] - opb;

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign fix_res  = op_div ? (op_f3[1] ? rem_fix : quo_fix)
                           : ((op_f3 == 3'b000) ? prod_fix[XLEN-1:0]
                                                : prod_fix[2*XLEN-1:XLEN]);

`ifdef ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;

  // Sign-extend (or zero-extend) both operands to 2*XLEN; the low 2*XLEN bits
  // of the product are then correct for every signedness combination.
  assign fast_prod = {{XLEN{a_neg}}, A} * {{XLEN{b_neg}}, B};
  assign fast_res  = (func3 == 3'b000) ? fast_prod[XLEN-1:0]
                                       : fast_prod[2*XLEN-1:XLEN];
`endif

  assign in_ready = (state == S_IDLE);

  // Control FSM with registered result, flags and iteration state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      Q         <= '0;
      EQ        <= 1'b0;
      LT        <= 1'b0;
      LTU       <= 1'b0;
      count     <= '0;
      acc       <= '0;
      opb       <= '0;
      op_f3     <= 3'b000;
      op_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            EQ     <= (A == B);
            LT     <= lt_s;
            LTU    <= lt_u;
            op_f3  <= func3;
            op_div <= func3[2];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            count  <= '0;
            if (is_mul) begin
`ifdef ALU_FAST_MUL_EN
              Q         <= fast_res;
              out_valid <= 1'b1;
              state     <= S_DONE;
`else
              acc   <= {{XLEN{1'b0}}, b_mag};
              opb   <= a_mag;
              state <= S_MUL;
`endif
            end else if (is_div) begin
              if (is_special) begin
                Q         <= special_res;
                out_valid <= 1'b1;
                state     <= S_DONE;
              end else begin
                acc   <= {{XLEN{1'b0}}, a_mag};
                opb   <= b_mag;
                state <= S_DIV;
              end
            end else begin
              Q         <= base_res;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end

        S_MUL: begin
          acc   <= {mul_sum, acc[XLEN-1:1]};
          count <= count + 1'b1;
          if (count == SW'(XLEN-1)) state <= S_FIX;
        end

        S_DIV: begin
          if (div_ge) acc <= {div_sub, acc[XLEN-2:0], 1'b1};
          else        acc <= {acc[2*XLEN-2:0], 1'b0};
          count <= count + 1'b1;
          if (count == SW'(XLEN-1)) state <= S_FIX;
        end

        S_FIX: begin
          Q         <= fix_res;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mdu
//  Purpose  : Directed-vector scoreboard bench for alu_mdu (XLEN=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mdu;
  localparam int XLEN = 32;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 2;
`endif
  localparam int DIV_LAT = XLEN + 2;

  // class vector: {ALUreg, ALUimm, AUIPC, LUI, JAL, JALR, Load, Store}
  localparam logic [7:0] C_REG = 8'h80, C_IMM = 8'h40, C_AUIPC = 8'h20, C_LUI = 8'h10;
  localparam logic [7:0] C_JAL = 8'h08, C_NONE = 8'h00;
  localparam logic [6:0] F7_0 = 7'b0000000, F7_ALT = 7'b0100000, F7_M = 7'b0000001;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, Q;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  shamt;
  logic [7:0]  cls;
  logic        EQ, LT, LTU;

  alu_mdu #(.XLEN(XLEN), .M_EXT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .func3(func3), .func7(func7), .shamt(shamt),
    .isALUreg(cls[7]), .isALUimm(cls[6]), .isAUIPC(cls[5]), .isLUI(cls[4]),
    .isJAL(cls[3]), .isJALR(cls[2]), .isLoad(cls[1]), .isStore(cls[0]),
    .out_valid(out_valid), .out_ready(out_ready), .Q(Q),
    .EQ(EQ), .LT(LT), .LTU(LTU)
  );

  typedef struct {
    int          id;
    logic [31:0] q;
    logic        eq, lt, ltu;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   lat_meas = 0;
  bit   seen = 0;
  int   txn = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: note accepts, measure latency on first out_valid, and pop/compare on handshake
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else begin
      if (in_valid && in_ready) begin
        acc_cyc = cyc + 1;
        seen    = 0;
      end
      if (out_valid && !seen) begin
        seen     = 1;
        lat_meas = cyc - acc_cyc + 1;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got Q=0x%08h with no outstanding operation", Q);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check($sformatf("t%0d_q", e.id), Q, e.q);
          check($sformatf("t%0d_flags", e.id), {29'd0, EQ, LT, LTU}, {29'd0, e.eq, e.lt, e.ltu});
          check($sformatf("t%0d_latency", e.id), lat_meas, e.lat);
        end
      end
    end
  end

  // Drive one operation and return once it has been accepted
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [7:0] c, input logic [4:0] sh,
                      input logic [31:0] q, input int lat, input bit push);
    int n;
    if (push) begin
      exp_t e;
      txn++;
      e.id  = txn;
      e.q   = q;
      e.eq  = (a == b);
      e.lt  = ($signed(a) < $signed(b));
      e.ltu = (a < b);
      e.lat = lat;
      sb.push_back(e);
    end
    A = a; B = b; func3 = f3; func7 = f7; cls = c; shamt = sh;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 32'hDEADBEEF; B = 32'h0BADF00D;
  endtask

  // Wait for the scoreboard to empty and the last handshake to complete
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; func3 = '0; func7 = '0; cls = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_q", Q, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_flags", {29'd0, EQ, LT, LTU}, 32'd0);
    @(posedge clk); #1;

    // Base operations
    send(32'd5,        32'd7,        3'b000, F7_0,   C_REG,   5'd0,  32'h0000000C, 1, 1);
    send(32'd5,        32'd7,        3'b000, F7_ALT, C_REG,   5'd0,  32'hFFFFFFFE, 1, 1);
    send(32'h80000000, 32'd4,        3'b101, F7_ALT, C_IMM,   5'd4,  32'hF8000000, 1, 1);
    send(32'h00000001, 32'd31,       3'b001, F7_0,   C_IMM,   5'd31, 32'h80000000, 1, 1);
    send(32'hFFFFFFFF, 32'd1,        3'b010, F7_0,   C_REG,   5'd0,  32'h00000001, 1, 1);
    send(32'hFFFFFFFF, 32'd1,        3'b011, F7_0,   C_REG,   5'd0,  32'h00000000, 1, 1);
    send(32'hF0F0F0F0, 32'hFF00FF00, 3'b100, F7_0,   C_REG,   5'd0,  32'h0FF00FF0, 1, 1);
    send(32'h00000000, 32'h12345000, 3'b000, F7_0,   C_LUI,   5'd0,  32'h12345000, 1, 1);
    send(32'h00000100, 32'h00000000, 3'b000, F7_0,   C_JAL,   5'd0,  32'h00000104, 1, 1);
    send(32'h00001000, 32'h00002000, 3'b000, F7_0,   C_AUIPC, 5'd0,  32'h00003000, 1, 1);
    send(32'd5,        32'd5,        3'b000, F7_0,   C_NONE,  5'd0,  32'h00000000, 1, 1);

    // Multiply
    send(32'hFFFFFFFF, 32'd3,        3'b000, F7_M,   C_REG,   5'd0,  32'hFFFFFFFD, MUL_LAT, 1);
    send(32'hFFFFFFFF, 32'd3,        3'b001, F7_M,   C_REG,   5'd0,  32'hFFFFFFFF, MUL_LAT, 1);
    send(32'hFFFFFFFF, 32'd3,        3'b010, F7_M,   C_REG,   5'd0,  32'hFFFFFFFF, MUL_LAT, 1);
    send(32'hFFFFFFFF, 32'd3,        3'b011, F7_M,   C_REG,   5'd0,  32'h00000002, MUL_LAT, 1);
    send(32'd12345,    32'd6789,     3'b000, F7_M,   C_REG,   5'd0,  32'h04FED79D, MUL_LAT, 1);

    // Divide corner cases
    send(32'd100,      32'd0,        3'b100, F7_M,   C_REG,   5'd0,  32'hFFFFFFFF, 1, 1);
    send(32'd100,      32'd0,        3'b110, F7_M,   C_REG,   5'd0,  32'h00000064, 1, 1);
    send(32'd100,      32'd0,        3'b101, F7_M,   C_REG,   5'd0,  32'hFFFFFFFF, 1, 1);
    send(32'h80000000, 32'hFFFFFFFF, 3'b100, F7_M,   C_REG,   5'd0,  32'h80000000, 1, 1);
    send(32'h80000000, 32'hFFFFFFFF, 3'b110, F7_M,   C_REG,   5'd0,  32'h00000000, 1, 1);

    // Iterative divide
    send(32'hFFFFFFF9, 32'd2,        3'b100, F7_M,   C_REG,   5'd0,  32'hFFFFFFFD, DIV_LAT, 1);
    send(32'hFFFFFFF9, 32'd2,        3'b110, F7_M,   C_REG,   5'd0,  32'hFFFFFFFF, DIV_LAT, 1);
    send(32'hFFFFFFFF, 32'h10,       3'b101, F7_M,   C_REG,   5'd0,  32'h0FFFFFFF, DIV_LAT, 1);
    send(32'hFFFFFFFF, 32'h10,       3'b111, F7_M,   C_REG,   5'd0,  32'h0000000F, DIV_LAT, 1);
    drain();

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    send(32'd100, 32'd7, 3'b101, F7_M, C_REG, 5'd0, 32'd14, DIV_LAT, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    if (!out_valid) check("bp_wait_timeout", 32'd0, 32'd1);
    repeat (10) begin
      check("bp_q_stable", Q, 32'd14);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    send(32'd100, 32'd7, 3'b111, F7_M, C_REG, 5'd0, 32'd2, DIV_LAT, 1);
    drain();

    // Reset in the middle of a divide; its result must never appear
    send(32'd1000, 32'd3, 3'b100, F7_M, C_REG, 5'd0, 32'd0, 0, 0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send(32'd1, 32'd1, 3'b000, F7_0, C_REG, 5'd0, 32'd2, 1, 1);
    drain();
    repeat (40) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle RV32I execute ALU.
- Performs the same base RV32I operations and adds RV32M multiply/divide.
- Uses a valid/ready handshake in, valid/ready handshake out, and a registered result.
- Sits in the execute stage; the core stalls issue while in_ready is low.

Parameters:
XLEN, 32, datapath width in bits (power of two, >= 8); shift amount width SW = $clog2(XLEN).
M_EXT, 1, 1 = decode RV32M ops (isALUreg && func7==7'b0000001); 0 = those encodings execute as base ops.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  operation presented.
in_ready  out  1  block can accept; high only in IDLE.
A, B  in  XLEN  operands.
func3  in  3  operation select.
func7  in  7  operation modifier.
shamt  in  SW  shift amount.
isALUreg, isALUimm, isAUIPC, isLUI, isJAL, isJALR, isLoad, isStore  in  1 each  instruction class (one-hot or all zero).
out_valid  out  1  result available.
out_ready  in  1  consumer takes result.
Q  out  XLEN  result.
EQ, LT, LTU  out  1 each  registered A==B, signed A<B, unsigned A<B of the accepted operands.

Behaviour:
- Reset (async, any state): state=IDLE, out_valid=0, Q=0, EQ=LT=LTU=0, counter=0. Any in-flight operation is discarded.
- Accept: in_valid && in_ready on a rising edge. Operands and decode are captured; later input changes are ignored.
- Base ops, identical semantics to the current ALU:
  - ALUreg/imm func3 000 ADD/SUB (SUB only when isALUreg && func7[5]), 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL/SRA by func7[5], 010 SLT, 011 SLTU.
  - AUIPC = A+B; LUI = B; JAL/JALR = A+4; Load/Store = A+B.
  - No class set: Q = 0.
  - Shifts use shamt. Results are truncated to XLEN.
- RV32M func3:
  - 000 MUL (low half)
  - 001 MULH (signed×signed, high half)
  - 010 MULHSU (signed A × unsigned B, high half)
  - 011 MULHU (high half)
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- States: IDLE, MUL, DIV, FIX, DONE.
  - IDLE: on accept, base op → DONE with Q written (latency 1). Multiply → MUL. Divide → DIV, except special cases, which go → DONE (latency 1).
  - MUL: radix-2 shift-add on operand magnitudes, 2·XLEN-bit product, XLEN iterations → FIX.
  - DIV: restoring divide on magnitudes, XLEN iterations → FIX.
  - FIX: apply sign correction, select the high or low half (or quotient/remainder), write Q → DONE.
  - Total latency for iterative ops = XLEN+2 cycles from accept edge to out_valid.
  - DONE: out_valid=1; Q and flags held stable until out_ready; on out_valid && out_ready → IDLE. No new accept in the same cycle.
- Special cases (latency 1):
  - Divide by zero: DIV/DIVU Q = all ones; REM/REMU Q = A.
  - Signed overflow (A = most negative, B = -1): DIV Q = A; REM Q = 0.
- Sign rules: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- out_valid never asserts without a preceding accept; in_ready=0 in MUL/DIV/FIX/DONE.

Optional Feature:
ALU_FAST_MUL_EN
- Defined: multiplies use a single combinational XLEN×XLEN multiplier; IDLE → DONE with latency 1, and the MUL state is unused. Divide is unchanged.
- Undefined: iterative multiply with latency XLEN+2, as above.

Test Plan:
- Reset: hold rst, then release → out_valid=0, Q=0, in_ready=1.
- ADD (XLEN=32): A=5, B=7, isALUreg, func3=000, func7=0 → out_valid next cycle, Q=12, EQ=0, LT=1, LTU=1.
- MUL/MULH: A=0xFFFFFFFF, B=3.
  - MUL → Q=0xFFFFFFFD; MULH → Q=0xFFFFFFFF; MULHU → Q=0x00000002.
  - out_valid exactly 34 cycles after accept (1 cycle if ALU_FAST_MUL_EN).
- Divide special cases:
  - A=100, B=0: DIV → 0xFFFFFFFF, REM → 100, latency 1.
  - A=0x80000000, B=0xFFFFFFFF: DIV → 0x80000000, REM → 0.
- Backpressure: DIVU 100/7 with out_ready=0 for 10 cycles after out_valid → Q=14 stable, in_ready=0. Then REMU 100/7 → Q=2. Also DIV -7/2 → 0xFFFFFFFD, REM -7/2 → 0xFFFFFFFF.
- Reset mid-operation: assert rst 10 cycles into DIV → out_valid=0 immediately, in_ready=1 after release. A following ADD 1+1 → Q=2, with no stale result emitted.
